// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: load modes, MEM-stage FSM states and the
// request attributes latched when a data-memory access is accepted.
package mips_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned HALF_W = 16;

   localparam logic [1:0] LM_WORD  = 2'b00;
   localparam logic [1:0] LM_HALF  = 2'b01;
   localparam logic [1:0] LM_HALFU = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Everything except the word address needed once the request is in flight
   typedef struct packed {
      logic              we;
      logic [1:0]        load_mode;
      logic              half_hi;
      logic [DATA_W-1:0] wdata;
   } req_attr_t;

   // Stores are word-only; halves need an even byte address; LM 11 acts as word
   function automatic logic access_aligned(input logic       is_write,
                                           input logic [1:0] mode,
                                           input logic [1:0] lo);
      logic ok;
      ok = (lo == 2'b00);
      if (!is_write && (mode == LM_HALF || mode == LM_HALFU)) begin
         ok = ~lo[0];
      end
      return ok;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide data-memory req/ack bus between the MEM stage and data memory.
interface mem_access_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-3:0] dmem_addr;
   logic [31:0]       dmem_wdata;
   logic              dmem_ack;
   logic [31:0]       dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Little-endian load formatting: LW passes the word, LH/LHU pick a half and
// sign- or zero-extend it.
module load_formatter
   import mips_pkg::*;
(
   input  logic [DATA_W-1:0] word,
   input  logic              addr_hi,
   input  logic [1:0]        load_mode,
   output logic [DATA_W-1:0] result_c
);

   logic [HALF_W-1:0] half_c;

   always_comb begin
      half_c   = addr_hi ? word[DATA_W-1:HALF_W] : word[HALF_W-1:0];
      result_c = word;
      case (load_mode)
         LM_HALF:  result_c = {{(DATA_W-HALF_W){half_c[HALF_W-1]}}, half_c};
         LM_HALFU: result_c = {{(DATA_W-HALF_W){1'b0}}, half_c};
         default:  result_c = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory responder: accepts aligned loads/stores in IDLE, runs
// one req/ack transaction while stalling the pipeline, returns formatted loads.
module mem_access_unit
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        load_mode,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              stall,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              misaligned,
   mem_access_unit_if.master dmem
);

   localparam int unsigned WADDR_W = ADDR_W - 2;

   state_e               state_q, state_d;
   logic                 req_q, req_d;
   logic [WADDR_W-1:0]   waddr_q, waddr_d;
   req_attr_t            attr_q, attr_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic                 rvalid_q, rvalid_d;

   logic                 access_c;
   logic                 aligned_c;
   logic [DATA_W-1:0]    fmt_c;

   assign access_c  = mem_read | mem_write;
   assign aligned_c = access_aligned(mem_write, load_mode, addr[1:0]);

   load_formatter u_fmt (
      .word      (dmem.dmem_rdata),
      .addr_hi   (attr_q.half_hi),
      .load_mode (attr_q.load_mode),
      .result_c  (fmt_c)
   );

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         waddr_q  <= '0;
         attr_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         waddr_q  <= waddr_d;
         attr_q   <= attr_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   // Next-state: DONE always returns to IDLE so its inputs are never sampled
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (access_c && aligned_c) state_d = BUSY;
         BUSY:    if (dmem.dmem_ack)         state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs and register updates
   always_comb begin
      stall      = 1'b0;
      misaligned = 1'b0;
      req_d      = req_q;
      waddr_d    = waddr_q;
      attr_d     = attr_q;
      rdata_d    = rdata_q;
      rvalid_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (access_c) begin
               if (aligned_c) begin
                  stall             = 1'b1;
                  req_d             = 1'b1;
                  waddr_d           = addr[ADDR_W-1:2];
                  attr_d.we         = mem_write;
                  attr_d.load_mode  = load_mode;
                  attr_d.half_hi    = addr[1];
                  attr_d.wdata      = wdata;
               end else begin
                  misaligned = 1'b1;
               end
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (dmem.dmem_ack) begin
               req_d = 1'b0;
               if (!attr_q.we) begin
                  rdata_d  = fmt_c;
                  rvalid_d = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   assign rdata           = rdata_q;
   assign rdata_valid     = rvalid_q;
   assign dmem.dmem_req   = req_q;
   assign dmem.dmem_we    = attr_q.we;
   assign dmem.dmem_addr  = waddr_q;
   assign dmem.dmem_wdata = attr_q.wdata;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory responder of the MIPS pipeline. Consumes the `MemRead`, `MemWrite` and `load_mode` controls produced in ID and carried down the pipeline, plus the ALU address and store data. Runs a req/ack transaction on the word-wide data memory, stalls the pipeline while the transaction is open, and returns load data formatted per `load_mode` (LW, LH sign-extended, LHU zero-extended).

## Interface
- ADDR_W, 32, byte-address width; memory word address is ADDR_W-2 bits
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  MEM-stage MemRead
- mem_write  in  1  MEM-stage MemWrite
- load_mode  in  2  00 word, 01 half signed, 10 half unsigned, 11 treated as word
- addr  in  ADDR_W  byte address (ALU result)
- wdata  in  32  store data (rt)
- stall  out  1  hold IF/ID/EX/MEM registers
- rdata  out  32  formatted load result to MEM/WB
- rdata_valid  out  1  one-cycle pulse when rdata is updated
- misaligned  out  1  one-cycle pulse; access suppressed
- dmem_req  out  1  transaction request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W-2  word address = addr[ADDR_W-1:2]
- dmem_wdata  out  32  write data
- dmem_ack  in  1  memory completion, one-cycle pulse
- dmem_rdata  in  32  read word, valid with dmem_ack

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request: stall=0, dmem_req=0.
- IDLE, request (mem_read or mem_write), aligned: stall=1 combinationally in this cycle. Latch addr, wdata, load_mode, and we=mem_write. Go to BUSY.
- Alignment rule: word access needs addr[1:0]=00. Half access needs addr[0]=0. Stores are word-only.
- IDLE, request, misaligned: misaligned=1 for this cycle. No transaction, stall=0, rdata unchanged, rdata_valid=0, stay in IDLE.
- mem_read and mem_write both high: write performed, read ignored, rdata_valid=0.
- BUSY: dmem_req=1; dmem_we/addr/wdata driven from the latches and held stable; stall=1. On dmem_ack: if read, rdata <= formatted dmem_rdata. Go to DONE.
- DONE: stall=0. rdata_valid=1 for reads, 0 for writes. Inputs this cycle still belong to the completing instruction and are not sampled. Go to IDLE unconditionally.
- Formatting is little-endian. Half select: addr[1]=0 → bits 15:0, addr[1]=1 → bits 31:16. LH sign-extends bit 15 of the half; LHU zero-fills.
- rdata holds its value until the next completed load.
- dmem_ack outside BUSY is ignored.

## Timing
- Reset values: state IDLE; stall=0, rdata=0, rdata_valid=0, misaligned=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0. Latches cleared.
- All dmem_* outputs and rdata are registered. stall and misaligned are combinational in IDLE.
- Latency, request seen in IDLE at cycle 0: dmem_req high from cycle 1. For ack in cycle k≥1, DONE is cycle k+1. Minimum occupancy is 3 cycles per access.
- No request is accepted in BUSY or DONE. Back-to-back accesses have one IDLE cycle between DONE and the next dmem_req.
- Reset asserted mid-BUSY: dmem_req drops asynchronously and the FSM returns to IDLE. The memory is reset by the same rst, so there is no outstanding ack.

## Structure
- Shared package `mips_pkg`:
  - LM_WORD=2'b00, LM_HALF=2'b01, LM_HALFU=2'b10
  - state enum {IDLE, BUSY, DONE}
- Sub-module `load_formatter`: combinational; inputs word, addr[1], load_mode; output 32-bit result. Instanced once and tested standalone.

## Test plan
- LW addr=0x100, memory returns 0xDEADBEEF with ack 2 cycles after req → dmem_addr=0x40, stall high 3 cycles, rdata=0xDEADBEEF with one rdata_valid pulse.
- LH addr=0x102, word 0x8001_1234 → rdata=0xFFFF8001. LHU same → 0x00008001. LH addr=0x100 → 0x00001234.
- SW addr=0x20, wdata=0xCAFEF00D, ack next cycle → dmem_we=1, dmem_addr=0x8, dmem_wdata=0xCAFEF00D, no rdata_valid, rdata unchanged.
- LW addr=0x103; then LH addr=0x101 → misaligned pulse each, dmem_req never rises, stall stays 0.
- rst asserted while BUSY → dmem_req and stall low immediately, all outputs at reset values; a later ack pulse is ignored.
- Two back-to-back LWs with mem_read held high → exactly two transactions. The DONE-cycle inputs are not re-issued.
